instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: captures one instruction, holds it on the datapath for
// ALU_LAT execute cycles, then spends one writeback cycle where the decoded
// format/rd decide between a register write, a silent retire, or an illegal pulse.
module instr_sequencer #(
  parameter int ALU_LAT = 1,   // 1..15
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      dp_instr,
  input  logic [2:0]       dp_format,
  input  logic [4:0]       dp_rd,
  output logic             wb_en,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  // Execute countdown starts at ALU_LAT-1 so that EXEC lasts ALU_LAT cycles.
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t           r_state;
  logic [3:0]       r_lat;
  logic [31:0]      r_dp_instr;
  logic [CNT_W-1:0] r_cnt;

  logic w_hs;
  logic w_fmt_ok;
  logic w_wb_live;

  // Only R-type (000) and I-type (001) are supported.
  assign w_fmt_ok  = (dp_format == 3'b000) || (dp_format == 3'b001);

  // A WB cycle only takes effect when not overridden by reset or flush.
  assign w_wb_live = (r_state == S_WB) && !rst && !flush;

  // Outputs are forced to their reset values while rst is held, so the very
  // first reset cycle already shows a quiet interface.
  assign in_ready    = !rst && (r_state != S_EXEC);
  assign w_hs        = in_valid && in_ready && !flush;
  assign wb_en       = w_wb_live && w_fmt_ok && (dp_rd != 5'd0);
  assign illegal     = w_wb_live && !w_fmt_ok;
  assign busy        = !rst && (r_state != S_IDLE);
  assign dp_instr    = rst ? 32'd0 : r_dp_instr;
  assign retired_cnt = rst ? '0 : r_cnt;

  // Sequencer FSM with capture register, latency countdown and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lat      <= 4'd0;
      r_dp_instr <= 32'd0;
      r_cnt      <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_dp_instr <= in_instr;
            r_lat      <= LAT_INIT;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_lat == 4'd0) r_state <= S_WB;
          else               r_lat   <= r_lat - 4'd1;
        end
        S_WB: begin
          // rd==0 still retires; only unsupported formats leave the count alone.
          if (w_fmt_ok) r_cnt <= r_cnt + CNT_W'(1);
          if (w_hs) begin
            r_dp_instr <= in_instr;
            r_lat      <= LAT_INIT;
            r_state    <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
